// File: rtl/mod5_seq_checker_if.sv
// Counter-observation bus between the mod-5 counter side and the sequence checker.
// master: the side that presents samples (counter / bench); slave: the checker.
interface mod5_seq_checker_if #(
    parameter int CNT_W  = 3,
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 4
);
    logic              cnt_valid;
    logic [CNT_W-1:0]  cnt_in;
    logic              err_clr;
    logic              locked;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_count;
    logic              err;
    logic [1:0]        err_code;
    logic [ERR_W-1:0]  err_count;

    modport master (
        output cnt_valid, cnt_in, err_clr,
        input  locked, wrap_pulse, wrap_count, err, err_code, err_count
    );

    modport slave (
        input  cnt_valid, cnt_in, err_clr,
        output locked, wrap_pulse, wrap_count, err, err_code, err_count
    );
endinterface

// File: rtl/mod5_seq_checker.sv
// Sequence checker for a mod-MOD up counter: verifies the 0..MOD-1 stepping,
// pulses on each legal wrap, counts wraps, and keeps sticky error status.
// Optional feature macro: MOD5_CHK_HOLD_EN (treat a repeated value in TRACK as a legal hold).
module mod5_seq_checker #(
    parameter int CNT_W  = 3,
    parameter int MOD    = 5,
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 4
) (
    input  logic clk,
    input  logic reset,
    mod5_seq_checker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [CNT_W:0]   MOD_L = (CNT_W+1)'(MOD);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(MOD - 1);
    localparam logic [1:0]       CODE_RANGE = 2'b01;
    localparam logic [1:0]       CODE_SEQ   = 2'b10;

    state_t            state;
    logic [CNT_W-1:0]  prev;
    logic              locked_r;
    logic              wrap_pulse_r;
    logic [WRAP_W-1:0] wrap_count_r;
    logic              err_r;
    logic [1:0]        err_code_r;
    logic [ERR_W-1:0]  err_count_r;

    state_t            st_nxt;
    logic [CNT_W-1:0]  prev_nxt;
    logic [CNT_W-1:0]  exp_val;
    logic              in_range;
    logic              err_ev;
    logic [1:0]        code_new;
    logic              wrap_ev;

    // Classify the current sample and decide the next state / events.
    always_comb begin
        st_nxt   = state;
        prev_nxt = prev;
        err_ev   = 1'b0;
        code_new = 2'b00;
        wrap_ev  = 1'b0;
        in_range = ({1'b0, bus.cnt_in} < MOD_L);
        exp_val  = (prev == LAST) ? '0 : prev + CNT_W'(1);
        if (bus.cnt_valid) begin
            case (state)
                IDLE: begin
                    if (in_range) begin
                        prev_nxt = bus.cnt_in;
                        st_nxt   = TRACK;
                    end else begin
                        err_ev   = 1'b1;
                        code_new = CODE_RANGE;
                        st_nxt   = FAULT;
                    end
                end
                TRACK: begin
                    if (!in_range) begin
                        err_ev   = 1'b1;
                        code_new = CODE_RANGE;
                        st_nxt   = FAULT;
                    end else if (bus.cnt_in == exp_val) begin
                        prev_nxt = bus.cnt_in;
                        wrap_ev  = (prev == LAST);
`ifdef MOD5_CHK_HOLD_EN
                    end else if (bus.cnt_in == prev) begin
                        // stalled counter: nothing changes
                        st_nxt = TRACK;
`endif
                    end else begin
                        err_ev   = 1'b1;
                        code_new = CODE_SEQ;
                        st_nxt   = FAULT;
                    end
                end
                FAULT: begin
                    if (bus.cnt_in == '0) begin
                        prev_nxt = '0;
                        st_nxt   = TRACK;
                    end
                end
                default: st_nxt = IDLE;
            endcase
        end
    end

    // State, tracking and all registered status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            prev         <= '0;
            locked_r     <= 1'b0;
            wrap_pulse_r <= 1'b0;
            wrap_count_r <= '0;
            err_r        <= 1'b0;
            err_code_r   <= 2'b00;
            err_count_r  <= '0;
        end else begin
            state        <= st_nxt;
            prev         <= prev_nxt;
            locked_r     <= (st_nxt == TRACK);
            wrap_pulse_r <= wrap_ev;
            if (wrap_ev)
                wrap_count_r <= wrap_count_r + WRAP_W'(1);
            // A new error outranks a simultaneous clear: the clear empties the
            // count first, so the fresh error lands as count 1.
            if (err_ev) begin
                err_r      <= 1'b1;
                err_code_r <= code_new;
                if (bus.err_clr)
                    err_count_r <= ERR_W'(1);
                else if (err_count_r != '1)
                    err_count_r <= err_count_r + ERR_W'(1);
            end else if (bus.err_clr) begin
                err_r       <= 1'b0;
                err_code_r  <= 2'b00;
                err_count_r <= '0;
            end
        end
    end

    assign bus.locked     = locked_r;
    assign bus.wrap_pulse = wrap_pulse_r;
    assign bus.wrap_count = wrap_count_r;
    assign bus.err        = err_r;
    assign bus.err_code   = err_code_r;
    assign bus.err_count  = err_count_r;

endmodule
